rv_hazard_ctrl: RTL

Parametrised hazard controller for the 5-stage RV32 pipeline. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives operand forwarding, load-use stalls, branch flushes and memory-wait freezes for the whole pipe. A small state machine holds a taken branch that arrives while data memory is busy, and applies it once memory is ready. Optional counters record stall, wait and flush activity.

---
 rtl/rv_pipe_pkg.sv | 14 +
 rtl/rv_hazard_ctrl_if.sv | 35 +++
 rtl/rv_fwd_sel.sv | 23 ++
 rtl/rv_hazard_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types: hazard FSM states and ALU operand forwarding selects.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    WAIT_FL = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/rv_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: stage register indices and
// status in, forwarding selects / enables / flushes / counters out.
interface rv_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic              id_use_rs1, id_use_rs2, ex_memread;
  logic              mem_regwrite, wb_regwrite, branch_taken, mem_busy;

  logic [1:0]        fwd_a, fwd_b;
  logic              pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic              id_ex_bubble, mem_wb_bubble;
  logic              flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt, wait_cnt, flush_cnt;

  modport master (
    output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
           id_use_rs1, id_use_rs2, ex_memread, mem_regwrite, wb_regwrite,
           branch_taken, mem_busy,
    input  fwd_a, fwd_b, pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble,
           mem_wb_bubble, flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect,
           state, stall_cnt, wait_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
           id_use_rs1, id_use_rs2, ex_memread, mem_regwrite, wb_regwrite,
           branch_taken, mem_busy,
    output fwd_a, fwd_b, pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble,
           mem_wb_bubble, flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect,
           state, stall_cnt, wait_cnt, flush_cnt
  );
endinterface

// File: rtl/rv_fwd_sel.sv
// Forwarding select for one ALU operand; the younger EX/MEM result wins over MEM/WB.
module rv_fwd_sel
  import rv_pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs))
      fwd = FWD_EXMEM;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs))
      fwd = FWD_MEMWB;
  end

endmodule

// File: rtl/rv_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipe: forwarding, load-use stall,
// branch flush and memory-wait freeze. Optional counters under HAZARD_PERF_CNT_EN.
//
// state   | meaning
// RUN     | normal flow; flush / freeze / load-use stall applied as needed
// WAIT    | pipe frozen on mem_busy, no branch pending
// WAIT_FL | pipe frozen on mem_busy, a taken branch waits to be applied
module rv_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int BR_STAGE = 3,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  rv_hazard_ctrl_if.slave hz
);

  hz_state_e state_q, state_nx;
  logic      lu, freeze, apply_fl, stall;

  rv_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs(hz.ex_rs1), .mem_rd(hz.mem_rd), .mem_regwrite(hz.mem_regwrite),
    .wb_rd(hz.wb_rd), .wb_regwrite(hz.wb_regwrite), .fwd(hz.fwd_a)
  );

  rv_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs(hz.ex_rs2), .mem_rd(hz.mem_rd), .mem_regwrite(hz.mem_regwrite),
    .wb_rd(hz.wb_rd), .wb_regwrite(hz.wb_regwrite), .fwd(hz.fwd_b)
  );

  assign lu = hz.ex_memread && (hz.ex_rd != '0) &&
              ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
               (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    freeze   = 1'b0;
    apply_fl = 1'b0;
    stall    = 1'b0;
    case (state_q)
      RUN, WAIT: begin
        if (hz.mem_busy) begin
          freeze   = 1'b1;
          state_nx = hz.branch_taken ? WAIT_FL : WAIT;
        end else begin
          state_nx = RUN;
          apply_fl = hz.branch_taken;
          stall    = lu & ~hz.branch_taken;
        end
      end
      WAIT_FL: begin
        // a further branch_taken here is ignored: only one flush can be pending
        if (hz.mem_busy) begin
          freeze = 1'b1;
        end else begin
          apply_fl = 1'b1;
          state_nx = RUN;
        end
      end
      default: begin
        state_nx = RUN;
        freeze   = hz.mem_busy;
        apply_fl = hz.branch_taken & ~hz.mem_busy;
        stall    = lu & ~hz.branch_taken & ~hz.mem_busy;
      end
    endcase
  end

  assign hz.pc_en         = ~freeze & ~stall;
  assign hz.if_id_en      = ~freeze & ~stall;
  assign hz.id_ex_en      = ~freeze;
  assign hz.ex_mem_en     = ~freeze;
  assign hz.id_ex_bubble  = stall;
  assign hz.mem_wb_bubble = freeze;
  assign hz.flush_if_id   = apply_fl;
  assign hz.flush_id_ex   = apply_fl;
  assign hz.flush_ex_mem  = apply_fl & (BR_STAGE == 3);
  assign hz.pc_redirect   = apply_fl;
  assign hz.state         = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, wait_q, flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      wait_q  <= '0;
      flush_q <= '0;
    end else begin
      if (stall && (stall_q != '1))    stall_q <= stall_q + CNT_W'(1);
      if (freeze && (wait_q != '1))    wait_q  <= wait_q + CNT_W'(1);
      if (apply_fl && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.wait_cnt  = wait_q;
  assign hz.flush_cnt = flush_q;
`else
  assign hz.stall_cnt = {CNT_W{1'b0}};
  assign hz.wait_cnt  = {CNT_W{1'b0}};
  assign hz.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
